// File: rtl/score_pkg.sv
// Shared constants and helpers for the score keeper: BCD increment and
// active-low seven-segment decode.
package score_pkg;

    localparam int              MAX_DIGITS = 8;
    localparam logic [31:0]     BCD_MAX    = 32'h9999_9999;
    localparam logic [6:0]      SEG_BLANK  = 7'h7F;

    function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    return 7'h01;
            4'd1:    return 7'h4F;
            4'd2:    return 7'h12;
            4'd3:    return 7'h06;
            4'd4:    return 7'h4C;
            4'd5:    return 7'h24;
            4'd6:    return 7'h20;
            4'd7:    return 7'h0F;
            4'd8:    return 7'h00;
            4'd9:    return 7'h04;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Ripple +1 over the low ndig digits; bit 32 is the carry out of the top digit.
    function automatic logic [32:0] bcd_inc(input logic [31:0] vec, input int ndig);
        logic [31:0] r;
        logic        c;
        r = vec;
        c = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < ndig && c) begin
                if (vec[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = vec[4*i +: 4] + 4'd1;
                    c           = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

endpackage

// File: rtl/seg7_scan.sv
// Time-multiplexed common-anode display driver: rotates through DIGITS
// digits, SCAN_DIV clocks each, with optional leading-zero blanking.
module seg7_scan
    import score_pkg::*;
#(
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 4096,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  dp_en,
    output logic [6:0]            a_to_g,
    output logic [DIGITS-1:0]     an,
    output logic                  dp
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CW-1:0]   scan_cnt;
    logic [IW-1:0]   idx;
    logic [3:0]      nib;
    logic [DIGITS:0] hz;
    logic            blank;

    // hz[i]: digit i and every digit above it are zero
    always_comb begin
        nib        = 4'd0;
        blank      = 1'b0;
        hz         = '0;
        hz[DIGITS] = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            hz[i] = hz[i+1] && (value[4*i +: 4] == 4'd0);
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib   = value[4*i +: 4];
                blank = (BLANK_LZ != 0) && (i > 0) && hz[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            scan_cnt <= '0;
            idx      <= '0;
            an       <= '1;
            a_to_g   <= SEG_BLANK;
            dp       <= 1'b1;
        end else begin
            if (scan_cnt == CW'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                idx      <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            an     <= ~(DIGITS'(1) << idx);
            a_to_g <= blank ? SEG_BLANK : seg7_decode(nib);
            dp     <= ~(dp_en && (idx == '0));
        end
    end

endmodule

// File: rtl/score_board.sv
// Game score keeper: BCD score from plusone rising edges, high score with
// record flag, and a scanned seven-segment view of either value.
module score_board
    import score_pkg::*;
#(
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 4096,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  plusone,
    input  logic                  game_reset,
    input  logic                  show_high,
    output logic [4*DIGITS-1:0]   score,
    output logic [4*DIGITS-1:0]   high_score,
    output logic                  new_record,
    output logic [6:0]            a_to_g,
    output logic [DIGITS-1:0]     an,
    output logic                  dp
);

    localparam int W = 4 * DIGITS;

    logic          plusone_q;
    logic          event_p;
    logic [31:0]   score_ext;
    logic [32:0]   inc_full;
    logic [W-1:0]  inc;
    logic          sat;
    logic          unused_hi;

    assign event_p = plusone && !plusone_q;

    always_comb begin
        score_ext        = '0;
        score_ext[W-1:0] = score;
    end

    assign inc_full = bcd_inc(score_ext, DIGITS);
    assign inc      = inc_full[W-1:0];
    assign sat      = inc_full[32];

    generate
        if (W < 32) begin : g_pad
            assign unused_hi = |inc_full[31:W];
        end else begin : g_nopad
            assign unused_hi = 1'b0;
        end
    endgenerate

    // game_reset takes priority; a saturated score drops the event
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            plusone_q  <= 1'b0;
            score      <= '0;
            high_score <= '0;
            new_record <= 1'b0;
        end else begin
            plusone_q <= plusone;
            if (game_reset) begin
                score      <= '0;
                new_record <= 1'b0;
            end else if (event_p && !sat) begin
                score <= inc;
                if (inc > high_score) begin
                    high_score <= inc;
                    new_record <= 1'b1;
                end
            end
        end
    end

    seg7_scan #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV),
        .BLANK_LZ (BLANK_LZ)
    ) u_scan (
        .clk    (clk),
        .clr_n  (clr_n),
        .value  (show_high ? high_score : score),
        .dp_en  (new_record && !show_high),
        .a_to_g (a_to_g),
        .an     (an),
        .dp     (dp)
    );

endmodule
